pong_match_sequencer: RTL and testbench
=======================================

Name: pong_match_sequencer

Overview:
- Match-level controller for the Pong game. Owns the new_game / play / new_ball / over sequencing and the score counters, which the ball/paddle datapath does not keep.
- Generates the physics-step enable that paces ball and paddle updates. The step rate speeds up with the elapsed-seconds tens digit.
- Sits between the input/timer logic and the ball/paddle datapath. The datapath consumes step_en, ball_reset and serve_dir, and reports misses back.

Parameters:
- DIV_W, 20, width of step divider counter
- CLK_DIV_BASE, 500000, clk cycles per physics step at speed level 0
- SPEED_STEP, 50000, cycles removed from step period per speed level
- MIN_DIV, 100000, floor on step period
- SCORE_W, 4, score counter width
- WIN_SCORE, 5, points needed to win (must be < 2^SCORE_W)
- SERVE_DELAY, 60, physics steps to wait in new_ball before play resumes

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  level from button; rising edge detected internally
- pause  input  1  level; freezes play while high
- miss_left  input  1  1-cycle pulse: ball passed paddle1, point to player 2
- miss_right  input  1  1-cycle pulse: ball passed paddle2, point to player 1
- sec1  input  4  tens digit of game seconds (speed level, 0-9)
- step_en  output  1  1-cycle physics-update strobe to datapath
- ball_reset  output  1  1-cycle pulse: datapath recentres ball and paddles
- serve_dir  output  1  1 = serve toward right (player 2), 0 = toward left
- score1  output  SCORE_W  player 1 score
- score2  output  SCORE_W  player 2 score
- state_o  output  2  0 new_game, 1 play, 2 new_ball, 3 over
- winner  output  2  0 none, 1 player 1, 2 player 2

Behaviour:
- Reset (rst low, async): state new_game; score1 = score2 = 0; winner 0; serve_dir 1; step_en 0; ball_reset 0; divider 0; serve counter 0; start edge register 0.
- All state is registered; outputs are registered, so there is no combinational path from inputs to outputs.
- Start edge detection: start_q <= start; start_rise = start & ~start_q.
- Step period P:
  - P = max(MIN_DIV, CLK_DIV_BASE - sec1*SPEED_STEP), computed signed-safe so negative results clamp to MIN_DIV.
  - P is latched into a register at reset and at each divider wrap; a sec1 change takes effect on the next period only.
- Divider:
  - Counts 0..P-1 while running; the tick fires at count P-1, then the count wraps to 0.
  - Runs in new_ball and in play with pause low. Holds its value in play with pause high.
  - Cleared to 0 on entry to new_ball.
- step_en = registered tick, and only in play with pause low. It is never asserted in other states.
- new_game: scores 0, winner 0. On start_rise: go to new_ball, serve_dir <= 1, and pulse ball_reset on the transition cycle.
- new_ball:
  - step_en held 0.
  - The serve counter counts divider ticks; after SERVE_DELAY ticks, go to play and clear the serve counter.
  - Miss pulses are ignored.
- play:
  - miss_left alone: score2++, serve_dir <= 0.
  - miss_right alone: score1++, serve_dir <= 1.
  - Both in the same cycle: no score change, serve_dir unchanged, go to new_ball (replay).
  - After a single miss: if the incremented score == WIN_SCORE, go to over and set winner; otherwise go to new_ball.
  - ball_reset pulses 1 cycle on every transition into new_ball.
  - Misses are accepted even while pause is high.
- over:
  - Scores and winner frozen; step_en 0.
  - On start_rise: go to new_game, clearing scores and winner on entry.
  - A second start_rise is then needed to serve.
- start is ignored in play and new_ball.
- Scores never wrap: they saturate at WIN_SCORE.
- Reset mid-rally: immediate return to new_game with all outputs at reset values; no ball_reset pulse.

Test Plan (sim params: CLK_DIV_BASE=10, SPEED_STEP=2, MIN_DIV=4, WIN_SCORE=3, SERVE_DELAY=2, DIV_W=8):
- Reset, then start high for 5 cycles:
  - exactly one ball_reset pulse; state_o 0 -> 2; serve_dir=1.
  - After 2 ticks of 10 cycles, state_o=1.
  - step_en then pulses every 10 cycles.
- In play, set sec1=2 mid-period: current period completes at 10 cycles; subsequent step_en spacing is 6. With sec1=9, spacing is 4 (clamped).
- Hold pause high for 25 cycles in play: no step_en. On release, the next step_en arrives after the remaining count, not after a full period.
- Three miss_right pulses with serves between them:
  - score1 goes 1, 2, 3; after the third, state_o=3, winner=1, no ball_reset.
  - start_rise then gives state_o=0, scores 0. A second start_rise gives ball_reset.
- miss_left and miss_right asserted in the same cycle: scores unchanged, serve_dir unchanged, state_o=2, one ball_reset pulse.
- Assert rst low during new_ball mid-count: state_o=0, scores 0, step_en and ball_reset 0 in the same cycle (async). After release, miss pulses are ignored until a start is followed by a full serve delay.

Source files
------------

// File: rtl/pong_match_sequencer_if.sv
// Signal bundle between the Pong match sequencer, the input/timer logic and the
// ball/paddle datapath. The sequencer takes the slave side.
interface pong_match_sequencer_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               pause;
    logic               miss_left;
    logic               miss_right;
    logic [3:0]         sec1;
    logic               step_en;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [1:0]         state_o;
    logic [1:0]         winner;

    modport slave (
        input  start, pause, miss_left, miss_right, sec1,
        output step_en, ball_reset, serve_dir, score1, score2, state_o, winner
    );

    modport master (
        output start, pause, miss_left, miss_right, sec1,
        input  step_en, ball_reset, serve_dir, score1, score2, state_o, winner
    );
endinterface

// File: rtl/pong_match_sequencer.sv
// Match-level controller for Pong: new_game/play/new_ball/over sequencing, score
// keeping, and the speed-dependent physics-step strobe for the ball/paddle datapath.
module pong_match_sequencer #(
    parameter int DIV_W        = 20,
    parameter int CLK_DIV_BASE = 500000,
    parameter int SPEED_STEP   = 50000,
    parameter int MIN_DIV      = 100000,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_DELAY  = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    pong_match_sequencer_if.slave bus
);

    localparam logic [1:0] ST_NEW_GAME = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_NEW_BALL = 2'd2;
    localparam logic [1:0] ST_OVER     = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ZERO = '0;
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);

    // Registered state
    logic [1:0]         state_q,     state_d;
    logic               start_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   period_q;
    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0] score1_q,    score1_d;
    logic [SCORE_W-1:0] score2_q,    score2_d;
    logic [1:0]         winner_q,    winner_d;
    logic               serve_dir_q, serve_dir_d;
    logic               step_en_q;
    logic               ball_reset_q;

    // Combinational helpers
    logic               start_rise;
    logic               div_run;
    logic               tick;
    logic               enter_new_ball;
    logic [DIV_W-1:0]   period_calc;
    logic [SCORE_W-1:0] score1_inc;
    logic [SCORE_W-1:0] score2_inc;

    assign start_rise = bus.start & ~start_q;
    assign div_run    = (state_q == ST_NEW_BALL) || ((state_q == ST_PLAY) && !bus.pause);
    assign tick       = div_run && (cnt_q == period_q - DIV_W'(1));

    // Scores saturate; in practice the match ends before they can pass WIN_SCORE.
    assign score1_inc = (score1_q >= SCORE_WIN) ? score1_q : score1_q + SCORE_W'(1);
    assign score2_inc = (score2_q >= SCORE_WIN) ? score2_q : score2_q + SCORE_W'(1);

    // Step period shrinks with the speed level; the comparison is done in int so a
    // reduction larger than the base period clamps instead of wrapping.
    always_comb begin
        if (int'(bus.sec1) * SPEED_STEP > CLK_DIV_BASE - MIN_DIV)
            period_calc = DIV_W'(MIN_DIV);
        else
            period_calc = DIV_W'(CLK_DIV_BASE - int'(bus.sec1) * SPEED_STEP);
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        serve_cnt_d    = serve_cnt_q;
        score1_d       = score1_q;
        score2_d       = score2_q;
        winner_d       = winner_q;
        serve_dir_d    = serve_dir_q;
        enter_new_ball = 1'b0;

        case (state_q)
            ST_NEW_GAME: begin
                score1_d = SCORE_ZERO;
                score2_d = SCORE_ZERO;
                winner_d = WIN_NONE;
                if (start_rise) begin
                    serve_dir_d    = 1'b1;
                    enter_new_ball = 1'b1;
                end
            end

            ST_NEW_BALL: begin
                if (tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SERVE_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (bus.miss_left && bus.miss_right) begin
                    enter_new_ball = 1'b1;
                end else if (bus.miss_left) begin
                    score2_d    = score2_inc;
                    serve_dir_d = 1'b0;
                    if (score2_inc == SCORE_WIN) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        enter_new_ball = 1'b1;
                    end
                end else if (bus.miss_right) begin
                    score1_d    = score1_inc;
                    serve_dir_d = 1'b1;
                    if (score1_inc == SCORE_WIN) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P1;
                    end else begin
                        enter_new_ball = 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_NEW_GAME;
                    score1_d = SCORE_ZERO;
                    score2_d = SCORE_ZERO;
                    winner_d = WIN_NONE;
                end
            end

            default: state_d = ST_NEW_GAME;
        endcase

        if (enter_new_ball) begin
            state_d     = ST_NEW_BALL;
            serve_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_NEW_GAME;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            period_q     <= DIV_W'(CLK_DIV_BASE);
            serve_cnt_q  <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            winner_q     <= WIN_NONE;
            serve_dir_q  <= 1'b1;
            step_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= bus.start;
            serve_cnt_q  <= serve_cnt_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            step_en_q    <= tick && (state_q == ST_PLAY);
            ball_reset_q <= enter_new_ball;

            // A new speed level is only picked up at a wrap, never mid-period.
            if (tick)
                period_q <= period_calc;

            if (enter_new_ball)
                cnt_q <= '0;
            else if (tick)
                cnt_q <= '0;
            else if (div_run)
                cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    assign bus.step_en    = step_en_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.state_o    = state_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer: sequencing, step pacing, pause, scoring,
// replay on double miss and asynchronous reset mid-serve.
module tb_pong_match_sequencer;

    localparam int DIV_W        = 8;
    localparam int CLK_DIV_BASE = 10;
    localparam int SPEED_STEP   = 2;
    localparam int MIN_DIV      = 4;
    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 3;
    localparam int SERVE_DELAY  = 2;

    localparam logic [1:0] ST_NEW_GAME = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_NEW_BALL = 2'd2;
    localparam logic [1:0] ST_OVER     = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total      = 0;
    int bad        = 0;
    int br_count   = 0;
    int step_count = 0;

    pong_match_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

    pong_match_sequencer #(
        .DIV_W       (DIV_W),
        .CLK_DIV_BASE(CLK_DIV_BASE),
        .SPEED_STEP  (SPEED_STEP),
        .MIN_DIV     (MIN_DIV),
        .SCORE_W     (SCORE_W),
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_DELAY (SERVE_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.ball_reset === 1'b1) br_count++;
        if (bus.step_en === 1'b1) step_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (bus.state_o !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.step_en !== 1'b1 && n < limit);
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        bus.miss_left  = l;
        bus.miss_right = r;
        @(negedge clk);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int br0;
        int st0;

        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        bus.sec1       = 4'd0;

        // Reset values
        cycles(2);
        check("rst_state",      bus.state_o,    ST_NEW_GAME);
        check("rst_score1",     bus.score1,     0);
        check("rst_score2",     bus.score2,     0);
        check("rst_winner",     bus.winner,     0);
        check("rst_serve_dir",  bus.serve_dir,  1);
        check("rst_step_en",    bus.step_en,    0);
        check("rst_ball_reset", bus.ball_reset, 0);
        rst = 1'b1;
        cycles(2);
        check("idle_new_game", bus.state_o, ST_NEW_GAME);

        // Start held for 5 cycles: one serve, then play after 2 ticks of 10
        br0 = br_count;
        bus.start = 1'b1;
        cycles(1);
        check("start_new_ball",  bus.state_o,    ST_NEW_BALL);
        check("start_ball_rst",  bus.ball_reset, 1);
        check("start_serve_dir", bus.serve_dir,  1);
        cycles(4);
        bus.start = 1'b0;
        wait_state(ST_PLAY, 40, n);
        check("serve_delay", n + 4, 20);
        check("start_one_ball_reset", br_count - br0, 1);

        // Step pacing and speed levels
        wait_step(30, n);
        check("first_step", n, 10);
        wait_step(30, n);
        check("step_period_10", n, 10);
        cycles(3);
        bus.sec1 = 4'd2;
        wait_step(30, n);
        check("old_period_completes", n + 3, 10);
        bus.sec1 = 4'd9;
        wait_step(30, n);
        check("period_sec1_2", n, 6);
        wait_step(30, n);
        check("period_clamped", n, 4);
        bus.sec1 = 4'd0;
        wait_step(30, n);
        check("period_latched_at_wrap", n, 4);
        wait_step(30, n);
        check("period_restored", n, 10);

        // Pause freezes the divider mid-count
        cycles(3);
        bus.pause = 1'b1;
        st0 = step_count;
        cycles(25);
        check("pause_no_step", step_count - st0, 0);
        check("pause_state",   bus.state_o, ST_PLAY);
        bus.pause = 1'b0;
        wait_step(30, n);
        check("pause_resume_remaining", n, 7);

        // Start is ignored during play
        bus.start = 1'b1;
        cycles(2);
        check("start_ignored_play", bus.state_o, ST_PLAY);
        bus.start = 1'b0;

        // Player 1 wins with three points
        for (int k = 1; k <= 3; k++) begin
            br0 = br_count;
            pulse_miss(1'b0, 1'b1);
            check("p1_score", bus.score1, k);
            check("p1_serve_dir", bus.serve_dir, 1);
            if (k < 3) begin
                check("p1_new_ball",  bus.state_o,    ST_NEW_BALL);
                check("p1_ball_rst",  bus.ball_reset, 1);
                st0 = step_count;
                wait_state(ST_PLAY, 40, n);
                check("p1_serve_delay", n, 20);
                check("p1_no_step_in_serve", step_count - st0, 0);
            end else begin
                check("p1_over",     bus.state_o,    ST_OVER);
                check("p1_winner",   bus.winner,     1);
                check("p1_no_reset", br_count - br0, 0);
            end
        end

        // Over: frozen, misses ignored, start returns to new_game
        st0 = step_count;
        cycles(12);
        check("over_no_step", step_count - st0, 0);
        pulse_miss(1'b1, 1'b0);
        check("over_miss_ignored", bus.score2,  0);
        check("over_hold_state",   bus.state_o, ST_OVER);
        check("over_hold_score1",  bus.score1,  3);
        br0 = br_count;
        bus.start = 1'b1;
        cycles(1);
        check("restart_state",  bus.state_o, ST_NEW_GAME);
        check("restart_score1", bus.score1,  0);
        check("restart_winner", bus.winner,  0);
        bus.start = 1'b0;
        cycles(2);
        check("restart_needs_second_start", bus.state_o, ST_NEW_GAME);
        check("restart_no_ball_reset", br_count - br0, 0);
        bus.start = 1'b1;
        cycles(1);
        bus.start = 1'b0;
        check("second_start_new_ball", bus.state_o, ST_NEW_BALL);
        check("second_start_ball_rst", br_count - br0, 1);

        // Miss during new_ball is ignored
        pulse_miss(1'b0, 1'b1);
        check("nb_miss_ignored", bus.score1, 0);
        wait_state(ST_PLAY, 40, n);
        check("nb_serve_delay", n, 19);

        // Player 2 point, then double miss replays
        pulse_miss(1'b1, 1'b0);
        check("p2_score",     bus.score2,    1);
        check("p2_serve_dir", bus.serve_dir, 0);
        check("p2_new_ball",  bus.state_o,   ST_NEW_BALL);
        wait_state(ST_PLAY, 40, n);
        check("p2_serve_delay", n, 20);
        br0 = br_count;
        pulse_miss(1'b1, 1'b1);
        check("both_state",     bus.state_o,   ST_NEW_BALL);
        check("both_score1",    bus.score1,    0);
        check("both_score2",    bus.score2,    1);
        check("both_serve_dir", bus.serve_dir, 0);
        cycles(2);
        check("both_one_ball_reset", br_count - br0, 1);

        // Asynchronous reset mid-serve
        cycles(3);
        rst = 1'b0;
        #1;
        check("arst_state",      bus.state_o,    ST_NEW_GAME);
        check("arst_score2",     bus.score2,     0);
        check("arst_serve_dir",  bus.serve_dir,  1);
        check("arst_step_en",    bus.step_en,    0);
        check("arst_ball_reset", bus.ball_reset, 0);
        cycles(1);
        rst = 1'b1;
        br0 = br_count;
        pulse_miss(1'b0, 1'b1);
        pulse_miss(1'b1, 1'b0);
        check("post_rst_miss_s1", bus.score1,  0);
        check("post_rst_miss_s2", bus.score2,  0);
        check("post_rst_state",   bus.state_o, ST_NEW_GAME);
        cycles(2);
        check("post_rst_no_ball_reset", br_count - br0, 0);
        bus.start = 1'b1;
        cycles(1);
        bus.start = 1'b0;
        check("post_rst_serve", bus.state_o, ST_NEW_BALL);
        pulse_miss(1'b0, 1'b1);
        check("post_rst_nb_miss_ignored", bus.score1, 0);
        wait_state(ST_PLAY, 40, n);
        check("post_rst_serve_delay", n, 19);
        pulse_miss(1'b0, 1'b1);
        check("post_rst_point", bus.score1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
